// File: rtl/lcd_dec_fmt.sv
// Text-formatting stage for a 4x20 character LCD: holds the frame buffer and writes
// right-aligned decimal fields into it using a sequential double-dabble conversion.
module lcd_dec_fmt #(
   parameter int          WIDTH  = 16,
   parameter int          DIGITS = 5,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic              ckht,
   input  logic              rst,
   input  logic              start,
   input  logic              clr,
   input  logic [WIDTH-1:0]  value,
   input  logic [1:0]        row,
   input  logic [4:0]        col,
   input  logic              lead_zero,
   output logic              busy,
   output logic              done,
   output logic [159:0]      lcd_h0,
   output logic [159:0]      lcd_h1,
   output logic [159:0]      lcd_h2,
   output logic [159:0]      lcd_h3
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int KW = $clog2(DIGITS + 1);
   localparam int BW = 4 * DIGITS;

   // Handshake: start/clr are accepted only on an edge where busy=0 (clr wins);
   // busy stays high until the edge that raises the one-cycle done pulse.
   typedef enum logic [1:0] {IDLE, CLEAR, CONV, WRITE} state_t;

   state_t              state;
   logic [7:0]          fb [4][20];
   logic [WIDTH-1:0]    shreg;
   logic [BW-1:0]       bcd;
   logic [BW-1:0]       bcd_adj;
   logic [BW+WIDTH-1:0] shifted;
   logic [CW-1:0]       cnt;
   logic [KW-1:0]       k;
   logic [1:0]          row_q;
   logic [4:0]          col_q;
   logic                lz_q;
   logic                seen_nz;
   logic [3:0]          digit;
   logic [5:0]          col_k;
   logic                last_digit;
   logic                suppress;
   logic [7:0]          ch;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      shifted    = {bcd_adj, shreg} << 1;
      // WRITE consumes digits from the top of bcd, shifting one nibble per cycle
      digit      = bcd[BW-1 -: 4];
      col_k      = {1'b0, col_q} + 6'(k);
      last_digit = (k == KW'(DIGITS - 1));
      suppress   = !lz_q && !seen_nz && (digit == 4'd0) && !last_digit;
      ch         = suppress ? BLANK : (8'h30 + {4'd0, digit});
   end

   always_ff @(posedge ckht or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         shreg   <= '0;
         bcd     <= '0;
         cnt     <= '0;
         k       <= '0;
         row_q   <= '0;
         col_q   <= '0;
         lz_q    <= 1'b0;
         seen_nz <= 1'b0;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 20; c++)
               fb[r][c] <= BLANK;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end else if (start) begin
                  shreg   <= value;
                  bcd     <= '0;
                  cnt     <= '0;
                  row_q   <= row;
                  col_q   <= col;
                  lz_q    <= lead_zero;
                  seen_nz <= 1'b0;
                  state   <= CONV;
                  busy    <= 1'b1;
               end
            end
            CLEAR: begin
               for (int r = 0; r < 4; r++)
                  for (int c = 0; c < 20; c++)
                     fb[r][c] <= BLANK;
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            CONV: begin
               bcd   <= shifted[BW+WIDTH-1:WIDTH];
               shreg <= shifted[WIDTH-1:0];
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= WRITE;
                  k     <= '0;
               end
            end
            WRITE: begin
               // Columns past the right edge are dropped rather than wrapped
               if (col_k < 6'd20)
                  fb[row_q][col_k[4:0]] <= ch;
               if (digit != 4'd0)
                  seen_nz <= 1'b1;
               bcd <= {bcd[BW-5:0], 4'd0};
               k   <= k + 1'b1;
               if (last_digit) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar c = 0; c < 20; c++) begin : g_col
      assign lcd_h0[159-8*c -: 8] = fb[0][c];
      assign lcd_h1[159-8*c -: 8] = fb[1][c];
      assign lcd_h2[159-8*c -: 8] = fb[2][c];
      assign lcd_h3[159-8*c -: 8] = fb[3][c];
   end

endmodule
